// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the serial pattern-match controller.
//   - FSM state encoding
//   - default pattern length and match-counter width
//   - pattern loaded at reset
package seq_ctrl_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    localparam logic [3:0] RST_PATTERN = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_match_ctrl_if.sv
// Handshake and data bundle for seq_match_ctrl.
//   master : drives configuration, run control and the serial stream
//   slave  : the controller; returns cfg_ready, match, busy, done, match_count
// PAT_W and CNT_W must match the parameters of the attached controller.
interface seq_match_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic             start;
    logic             abort;
    logic             in;
    logic             in_valid;
    logic             match;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_count;

    modport master (
        output cfg_valid, cfg_pattern, cfg_overlap, cfg_target,
        output start, abort, in, in_valid,
        input  cfg_ready, match, busy, done, match_count
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_overlap, cfg_target,
        input  start, abort, in, in_valid,
        output cfg_ready, match, busy, done, match_count
    );
endinterface

// File: rtl/seq_match_core.sv
// Shift history, fill counter and pattern compare.
//   clk, reset_n : clock, synchronous active-low reset
//   en           : current bit is accepted (RUN, in_valid, no abort)
//   clear        : empty the history at the start of a run
//   overlap      : 1 keeps the history across a match
//   pattern      : registered pattern, MSB is the oldest bit
//   in           : current serial bit
//   hit          : combinational match on the current bit
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clear,
    input  logic             overlap,
    input  logic [PAT_W-1:0] pattern,
    input  logic             in,
    output logic             hit
);
    localparam int FW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

    logic [PAT_W-2:0] hist;
    logic [FW-1:0]    fill;
    logic [PAT_W-1:0] window;

    // Oldest retained bit lands in the MSB, matching the pattern order.
    assign window = {hist, in};
    // fill saturates at PAT_W-1, so equality stands for "at least".
    assign hit    = en && (fill == FILL_MAX) && (window == pattern);

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= window[PAT_W-2:0];
            if (hit && !overlap) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + FW'(1);
            end
        end
    end
endmodule

// File: rtl/seq_match_ctrl.sv
// Serial pattern-match run controller.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : configuration write handshake, start/abort, serial input,
//                  match pulse, busy, done pulse and registered match count
//
//   state | meaning
//   IDLE  | configuration writable, waiting for start
//   RUN   | accepting bits and counting matches
//   DONE  | target reached, done pulse for one cycle
module seq_match_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic              clk,
    input logic              reset_n,
    seq_match_ctrl_if.slave  bus
);
    state_t           state, state_nxt;
    logic [PAT_W-1:0] pattern_q;
    logic             overlap_q;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] count_q;
    logic             accept;
    logic             run_clear;
    logic             hit;
    logic             final_hit;

    // Abort masks the bit so a coinciding completion neither matches nor counts.
    assign accept    = (state == RUN) && bus.in_valid && !bus.abort;
    assign run_clear = (state == IDLE) && bus.start;
    assign final_hit = hit && (target_q != '0) && ((count_q + CNT_W'(1)) == target_q);

    seq_match_core #(.PAT_W(PAT_W)) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (accept),
        .clear   (run_clear),
        .overlap (overlap_q),
        .pattern (pattern_q),
        .in      (bus.in),
        .hit     (hit)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (final_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A write in the same cycle as start is picked up by the run that follows.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pattern_q <= PAT_W'(RST_PATTERN);
            overlap_q <= 1'b0;
            target_q  <= CNT_W'(1);
        end else if ((state == IDLE) && bus.cfg_valid) begin
            pattern_q <= bus.cfg_pattern;
            overlap_q <= bus.cfg_overlap;
            target_q  <= bus.cfg_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || run_clear) begin
            count_q <= '0;
        end else if (hit) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.cfg_ready   = (state == IDLE);
    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.match       = hit;
    assign bus.match_count = count_q;
endmodule

// File: tb/tb_seq_match_ctrl.sv
module tb_seq_match_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    seq_match_ctrl_if #(.PAT_W(4), .CNT_W(8)) bus ();

    seq_match_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // drive set for the next cycle; one-shot controls are cleared after each tick
    logic       d_cv = 0, d_ovl = 0, d_st = 0, d_ab = 0, d_in = 0, d_iv = 0, d_rn = 1;
    logic [3:0] d_pat = 4'b0;
    logic [7:0] d_tgt = 8'd0;

    // reference model: run phase (0 idle, 1 running, 2 finished), config, count,
    // and the accepted bits that may still take part in a match
    int         m_phase;
    logic [3:0] m_pat;
    logic       m_ovl;
    logic [7:0] m_tgt;
    logic [7:0] m_cnt;
    bit         seg[$];

    int bitno;
    int mpos[$];

    function automatic bit model_match();
        logic [3:0] w;
        if (m_phase != 1 || !d_iv || d_ab) return 0;
        if (seg.size() < 3) return 0;
        w = {seg[seg.size()-3], seg[seg.size()-2], seg[seg.size()-1], d_in};
        return (w == m_pat);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_pat = 4'b1101;
        m_ovl = 0;
        m_tgt = 8'd1;
        m_cnt = 8'd0;
        seg.delete();
    endtask

    task automatic tick();
        bit em;
        @(negedge clk);
        bus.cfg_valid   = d_cv;
        bus.cfg_pattern = d_pat;
        bus.cfg_overlap = d_ovl;
        bus.cfg_target  = d_tgt;
        bus.start       = d_st;
        bus.abort       = d_ab;
        bus.in          = d_in;
        bus.in_valid    = d_iv;
        reset_n         = d_rn;
        #1;
        em = model_match();
        check_eq("cfg_ready", bus.cfg_ready, (m_phase == 0));
        check_eq("busy", bus.busy, (m_phase == 1));
        check_eq("done", bus.done, (m_phase == 2));
        check_eq("match", bus.match, em);
        check_eq("match_count", bus.match_count, m_cnt);
        if (d_iv) bitno++;
        if (bus.match === 1'b1) mpos.push_back(bitno);
        @(posedge clk);
        if (!d_rn) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    if (d_cv) begin
                        m_pat = d_pat;
                        m_ovl = d_ovl;
                        m_tgt = d_tgt;
                    end
                    if (d_st) begin
                        m_phase = 1;
                        m_cnt = 0;
                        seg.delete();
                    end
                end
                1: begin
                    if (d_ab) begin
                        m_phase = 0;
                    end else if (d_iv) begin
                        seg.push_back(d_in);
                        if (em) begin
                            m_cnt = m_cnt + 8'd1;
                            if (!m_ovl) seg.delete();
                            if (m_tgt != 0 && m_cnt == m_tgt) m_phase = 2;
                        end
                        while (seg.size() > 3) void'(seg.pop_front());
                    end
                end
                default: m_phase = 0;
            endcase
        end
        d_cv = 0; d_st = 0; d_ab = 0; d_iv = 0;
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) begin
            d_in = (s[i] == "1");
            d_iv = 1;
            tick();
        end
    endtask

    task automatic start_run(input logic [3:0] pat, input logic ovl, input logic [7:0] tgt);
        d_cv = 1; d_pat = pat; d_ovl = ovl; d_tgt = tgt; d_st = 1;
        tick();
        bitno = 0;
        mpos.delete();
    endtask

    task automatic stop_run();
        d_ab = 1;
        tick();
    endtask

    initial begin
        bus.cfg_valid = 0; bus.cfg_pattern = 0; bus.cfg_overlap = 0; bus.cfg_target = 0;
        bus.start = 0; bus.abort = 0; bus.in = 0; bus.in_valid = 0;
        repeat (2) @(posedge clk);
        model_reset();
        bitno = 0;
        d_rn = 1;
        #1;
        check_eq("rst_ready", bus.cfg_ready, 1);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_count", bus.match_count, 0);
        tick();

        // non-overlapping 1101 on 1101101
        start_run(4'b1101, 0, 8'd0);
        feed("1101101");
        #1;
        check_eq("nov_nmatch", mpos.size(), 1);
        if (mpos.size() > 0) check_eq("nov_pos", mpos[0], 4);
        check_eq("nov_count", bus.match_count, 1);
        stop_run();

        // overlapping
        start_run(4'b1101, 1, 8'd0);
        feed("1101101");
        #1;
        check_eq("ov_nmatch", mpos.size(), 2);
        if (mpos.size() > 1) begin
            check_eq("ov_pos0", mpos[0], 4);
            check_eq("ov_pos1", mpos[1], 7);
        end
        check_eq("ov_count", bus.match_count, 2);
        stop_run();

        // target 2 -> done one cycle after bit 7, then idle with count held
        start_run(4'b1101, 1, 8'd2);
        feed("1101101");
        #1;
        check_eq("tgt_done", bus.done, 1);
        check_eq("tgt_busy", bus.busy, 0);
        tick();
        #1;
        check_eq("tgt_done_low", bus.done, 0);
        check_eq("tgt_idle", bus.cfg_ready, 1);
        check_eq("tgt_count", bus.match_count, 2);

        // abort on the completing bit
        start_run(4'b1101, 0, 8'd0);
        feed("110");
        d_in = 1; d_iv = 1; d_ab = 1;
        tick();
        #1;
        check_eq("abort_nmatch", mpos.size(), 0);
        check_eq("abort_count", bus.match_count, 0);
        check_eq("abort_idle", bus.cfg_ready, 1);
        check_eq("abort_done", bus.done, 0);

        // 256 overlapping matches of 1111 wrap the counter
        start_run(4'b1111, 1, 8'd0);
        for (int i = 0; i < 259; i++) feed("1");
        #1;
        check_eq("wrap_nmatch", mpos.size(), 256);
        check_eq("wrap_count", bus.match_count, 0);
        check_eq("wrap_busy", bus.busy, 1);
        stop_run();

        // configuration write during a run is ignored
        start_run(4'b1101, 0, 8'd0);
        d_cv = 1; d_pat = 4'b0000; d_ovl = 1; d_tgt = 8'd5;
        #1;
        check_eq("cfg_run_ready", bus.cfg_ready, 0);
        tick();
        feed("1101");
        #1;
        check_eq("cfg_run_count", bus.match_count, 1);
        stop_run();

        // reset mid-run, then the reset configuration (1101, target 1) is live
        start_run(4'b0110, 1, 8'd0);
        feed("11");
        d_rn = 0;
        tick();
        d_rn = 1;
        #1;
        check_eq("mrst_ready", bus.cfg_ready, 1);
        check_eq("mrst_busy", bus.busy, 0);
        check_eq("mrst_done", bus.done, 0);
        check_eq("mrst_count", bus.match_count, 0);
        check_eq("mrst_match", bus.match, 0);
        d_st = 1;
        tick();
        feed("1101");
        #1;
        check_eq("mrst_defcfg_done", bus.done, 1);
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            d_cv  = ($urandom_range(0, 9) == 0);
            d_pat = 4'($urandom_range(0, 15));
            d_ovl = 1'($urandom_range(0, 1));
            d_tgt = 8'($urandom_range(0, 4));
            d_st  = ($urandom_range(0, 7) == 0);
            d_ab  = ($urandom_range(0, 49) == 0);
            d_iv  = ($urandom_range(0, 9) < 7);
            d_in  = 1'($urandom_range(0, 1));
            d_rn  = ($urandom_range(0, 199) != 0);
            tick();
        end
        d_rn = 1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_match_ctrl.md
SEQ_MATCH_CTRL -- requirements
Module: seq_match_ctrl

Interface
REQ-001 Parameter PAT_W, default 4, SHALL set the pattern length in bits.
REQ-002 Parameter CNT_W, default 8, SHALL set the match-counter and target width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 cfg_valid  input  1  configuration write request.
REQ-006 cfg_ready  output  1  high only in IDLE; a write occurs when cfg_valid and cfg_ready are both high.
REQ-007 cfg_pattern  input  PAT_W  pattern to detect; MSB is the first bit received.
REQ-008 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping detection.
REQ-009 cfg_target  input  CNT_W  number of matches that ends a run; 0 = run without limit.
REQ-010 start  input  1  arms a run from IDLE.
REQ-011 abort  input  1  ends a run without asserting done.
REQ-012 in  input  1  serial data bit.
REQ-013 in_valid  input  1  qualifies in; bits with in_valid=0 SHALL be ignored.
REQ-014 match  output  1  Mealy pulse, combinational from registered history plus the current in.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle pulse in DONE.
REQ-017 match_count  output  CNT_W  registered count of matches in the current or last run.

Function
REQ-018 The FSM SHALL have three states, IDLE, RUN and DONE, with these transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE on the match that makes match_count+1 equal cfg_target, when the target is non-zero.
  - RUN -> IDLE on abort.
  - DONE -> IDLE unconditionally after one cycle.
REQ-019 On a configuration write, the unit SHALL register pattern, overlap and target; the registered values SHALL stay frozen outside IDLE.
REQ-020 If cfg_valid and start are high in the same IDLE cycle, the unit SHALL latch the new configuration and start the run with that new configuration.
REQ-021 On IDLE->RUN, match_count, the bit history and the fill counter SHALL be cleared.
REQ-022 In RUN, match SHALL be high in the same cycle as in_valid=1 when all of the following hold:
  - the last PAT_W-1 accepted bits, followed by the current in, equal the pattern;
  - fill >= PAT_W-1, where fill counts accepted bits since the run start or since the last non-overlapping match.
REQ-023 On a match, match_count SHALL increment by one at the next edge.
  - In non-overlapping mode, fill SHALL reset to 0.
  - In overlapping mode, the history SHALL be retained.
REQ-024 With cfg_target=0, match_count SHALL wrap from 2^CNT_W-1 to 0, and the FSM SHALL stay in RUN until abort.
REQ-025 If abort coincides with a completing bit, abort SHALL win:
  - match stays 0;
  - match_count is not incremented;
  - the FSM goes to IDLE.
REQ-026 start in RUN or DONE, and cfg_valid outside IDLE, SHALL be ignored.
REQ-027 match SHALL be 0 outside RUN.
REQ-028 match_count SHALL hold its value through DONE and IDLE until the next start.
REQ-029 done SHALL assert in the cycle after the final match; the total latency from the final bit to done SHALL be 1 cycle.

Reset
REQ-030 With reset_n=0 at an edge, the unit SHALL take these values at that edge, overriding all other inputs:
  - state = IDLE;
  - match_count = 0, history = 0, fill = 0;
  - match = 0, busy = 0, done = 0, cfg_ready = 1;
  - pattern = 4'b1101, overlap = 0, target = 1.
REQ-031 A reset asserted mid-run SHALL abandon the run and SHALL NOT produce a done pulse.

Structure
REQ-032 A shared package seq_ctrl_pkg SHALL hold:
  - the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - the default values of PAT_W and CNT_W;
  - the reset pattern 4'b1101.
REQ-033 The shift history, fill counter and match compare SHALL live in one sub-module, seq_match_core.
  - It is driven by the controller's enable, clear and overlap signals.
  - The controller SHALL hold the FSM, the configuration registers and the counter.

Verification
REQ-034 Pattern 1101, overlap=0, target=0, stream 1101101 -> one match, on bit 4; match_count=1.
REQ-035 Same stream with overlap=1 -> matches on bits 4 and 7; match_count=2.
REQ-036 Target=2, overlap=1, stream 1101101 -> done is high one cycle after bit 7, then IDLE; busy drops; match_count stays 2.
REQ-037 Abort asserted together with bit 4 of 1101 -> no match, match_count=0, IDLE in the next cycle, no done.
REQ-038 Target=0, CNT_W=8, 256 matches of pattern 1111 with overlap=1 on a constant-1 stream -> match_count wraps to 0 and busy stays high.
REQ-039 Both of the following SHALL be covered:
  - cfg_valid during RUN is ignored: cfg_ready=0 and the pattern is unchanged.
  - reset_n=0 mid-run gives all outputs their reset values at the next edge.
